// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a bimodal branch history table.
//
// Resolves conditional branches and jumps in EX, raises a one-cycle
// registered flush with the corrected next PC on a mispredict, trains a
// table of 2-bit saturating counters, and serves fetch-stage predictions.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   if_pc                fetch-stage PC
//   if_pred_taken        prediction for if_pc (combinational)
//   ex_valid             EX-stage instruction valid
//   ex_pc, ex_target     EX-stage PC and taken target
//   ex_branch_req        conditional branch in EX
//   ex_jal_req           unconditional jump in EX
//   ex_fun3              branch funct3
//   ex_alu_res           compare result, bit 0 = less-than
//   ex_alu_zero          ALU zero flag
//   ex_pred_taken        prediction carried with the instruction
//   branch_res           actual taken (combinational)
//   flush, redirect_pc   registered mispredict flush and correct next PC
//   perf_branch_cnt      resolved conditional branches (saturating)
//   perf_miss_cnt        mispredicts (saturating)
module branch_resolve_bht #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] if_pc,
    output logic                  if_pred_taken,
    input  logic                  ex_valid,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic                  ex_branch_req,
    input  logic                  ex_jal_req,
    input  logic [2:0]            ex_fun3,
    input  logic [DATA_WIDTH-1:0] ex_alu_res,
    input  logic                  ex_alu_zero,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    output logic                  branch_res,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [CNT_WIDTH-1:0]  perf_branch_cnt,
    output logic [CNT_WIDTH-1:0]  perf_miss_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             cond_taken;
    logic             eff_valid;
    logic             mispredict;
    logic             bht_upd;
    logic             unused_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Bits outside the index window and above the less-than flag are don't-care.
    assign unused_bits = ^{if_pc[ADDR_WIDTH-1:IDX_W+2], if_pc[1:0],
                           ex_alu_res[DATA_WIDTH-1:1]};

    // Read before write: a same-cycle update at this index is not bypassed.
    assign if_pred_taken = bht[if_idx][1];

    always_comb begin
        cond_taken = 1'b0;
        case (ex_fun3)
            3'b000:          cond_taken = ex_alu_zero;
            3'b001:          cond_taken = ~ex_alu_zero;
            3'b100, 3'b110:  cond_taken = ex_alu_res[0];
            3'b101, 3'b111:  cond_taken = ~ex_alu_res[0];
            default:         cond_taken = 1'b0;
        endcase
    end

    assign branch_res = ex_jal_req | (ex_branch_req & cond_taken);

    // The instruction sitting in EX during a flush cycle is on the wrong path.
    assign eff_valid  = ex_valid & ~flush;
    assign mispredict = eff_valid & (branch_res != ex_pred_taken);
    assign bht_upd    = eff_valid & ex_branch_req & ~ex_jal_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= branch_res ? ex_target : ex_pc + ADDR_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (bht_upd) begin
            if (branch_res) begin
                if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
            end else begin
                if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branch_cnt <= '0;
            perf_miss_cnt   <= '0;
        end else begin
            if (bht_upd && (perf_branch_cnt != '1)) begin
                perf_branch_cnt <= perf_branch_cnt + 1'b1;
            end
            if (mispredict && (perf_miss_cnt != '1)) begin
                perf_miss_cnt <= perf_miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   if_pc;
    logic          if_pred_taken;
    logic          ex_valid;
    logic [31:0]   ex_pc;
    logic          ex_branch_req;
    logic          ex_jal_req;
    logic [2:0]    ex_fun3;
    logic [31:0]   ex_alu_res;
    logic          ex_alu_zero;
    logic          ex_pred_taken;
    logic [31:0]   ex_target;
    logic          branch_res;
    logic          flush;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] perf_branch_cnt;
    logic [CW-1:0] perf_miss_cnt;

    int total = 0;
    int bad   = 0;
    int exp_br   = 0;
    int exp_miss = 0;

    always #5 clk = ~clk;

    branch_resolve_bht #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .BHT_DEPTH(64), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch_req(ex_branch_req),
        .ex_jal_req(ex_jal_req), .ex_fun3(ex_fun3), .ex_alu_res(ex_alu_res),
        .ex_alu_zero(ex_alu_zero), .ex_pred_taken(ex_pred_taken),
        .ex_target(ex_target), .branch_res(branch_res), .flush(flush),
        .redirect_pc(redirect_pc), .perf_branch_cnt(perf_branch_cnt),
        .perf_miss_cnt(perf_miss_cnt)
    );

    typedef struct {
        logic [2:0] f3;
        logic       zero;
        logic       res0;
        logic       br;
        logic       jal;
        logic       exp;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic br, input logic jal,
                          input logic [2:0] f3, input logic zero, input logic res0,
                          input logic pred, input logic [31:0] tgt);
        ex_valid      = 1'b1;
        ex_pc         = pc;
        ex_branch_req = br;
        ex_jal_req    = jal;
        ex_fun3       = f3;
        ex_alu_zero   = zero;
        ex_alu_res    = {31'h0, res0};
        ex_pred_taken = pred;
        ex_target     = tgt;
    endtask

    task automatic clr_ex();
        ex_valid      = 1'b0;
        ex_branch_req = 1'b0;
        ex_jal_req    = 1'b0;
    endtask

    task automatic do_ex(input string name, input logic [31:0] pc, input logic br,
                         input logic jal, input logic [2:0] f3, input logic zero,
                         input logic res0, input logic pred, input logic [31:0] tgt,
                         input logic exp_res);
        set_ex(pc, br, jal, f3, zero, res0, pred, tgt);
        #1;
        chk({name, "_branch_res"}, {31'h0, branch_res}, {31'h0, exp_res});
        step();
        clr_ex();
    endtask

    task automatic chk_perf(input string name);
        chk({name, "_perf_br"},   {29'h0, perf_branch_cnt}, exp_br);
        chk({name, "_perf_miss"}, {29'h0, perf_miss_cnt},   exp_miss);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{3'b101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{3'b111, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{3'b010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        if_pc = 32'h100;
        ex_pc = 32'h0;
        ex_fun3 = 3'b000;
        ex_alu_res = 32'h0;
        ex_alu_zero = 1'b0;
        ex_pred_taken = 1'b0;
        ex_target = 32'h0;
        clr_ex();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_pred", {31'h0, if_pred_taken}, 32'h0);
        chk_perf("rst");

        // Decode table with ex_valid low: branch_res must still resolve.
        for (int i = 0; i < 14; i++) begin
            ex_fun3       = vecs[i].f3;
            ex_alu_zero   = vecs[i].zero;
            ex_alu_res    = {31'h0, vecs[i].res0};
            ex_branch_req = vecs[i].br;
            ex_jal_req    = vecs[i].jal;
            #1;
            chk($sformatf("vec%0d", i), {31'h0, branch_res}, {31'h0, vecs[i].exp});
        end
        clr_ex();
        step();
        chk("vec_no_flush", {31'h0, flush}, 32'h0);
        chk_perf("vec");

        // Cold-start beq taken at 0x100, predicted not-taken.
        do_ex("cold", 32'h100, 1, 0, 3'b000, 1, 0, 0, 32'h200, 1);
        exp_br = sat_inc(exp_br); exp_miss = sat_inc(exp_miss);
        chk("cold_flush", {31'h0, flush}, 32'h1);
        chk("cold_redirect", redirect_pc, 32'h200);
        chk("cold_pred", {31'h0, if_pred_taken}, 32'h1);
        chk_perf("cold");
        step();
        chk("cold_flush_one", {31'h0, flush}, 32'h0);
        chk("cold_redirect_hold", redirect_pc, 32'h200);

        // Saturation at 0x40: counter 1 -> 2 -> 3 -> 3 -> 3, then not-taken -> 2.
        if_pc = 32'h40;
        for (int i = 0; i < 4; i++) begin
            do_ex($sformatf("sat%0d", i), 32'h40, 1, 0, 3'b001, 0, 0, 1, 32'h300, 1);
            exp_br = sat_inc(exp_br);
            chk($sformatf("sat%0d_flush", i), {31'h0, flush}, 32'h0);
        end
        chk("sat_pred", {31'h0, if_pred_taken}, 32'h1);
        do_ex("satnt", 32'h40, 1, 0, 3'b001, 1, 0, 1, 32'h300, 0);
        exp_br = sat_inc(exp_br); exp_miss = sat_inc(exp_miss);
        chk("satnt_flush", {31'h0, flush}, 32'h1);
        chk("satnt_redirect", redirect_pc, 32'h44);
        chk("satnt_pred", {31'h0, if_pred_taken}, 32'h1);
        chk_perf("satnt");
        step();

        // Flush shadow at 0x100 (counter 2): mispredict, then blocked mispredict.
        if_pc = 32'h100;
        do_ex("shad1", 32'h100, 1, 0, 3'b000, 0, 0, 1, 32'h200, 0);
        exp_br = sat_inc(exp_br); exp_miss = sat_inc(exp_miss);
        chk("shad1_flush", {31'h0, flush}, 32'h1);
        chk("shad1_redirect", redirect_pc, 32'h104);
        do_ex("shad2", 32'h100, 1, 0, 3'b000, 1, 0, 0, 32'h500, 1);
        chk("shad2_flush", {31'h0, flush}, 32'h0);
        chk("shad2_redirect", redirect_pc, 32'h104);
        chk("shad2_pred", {31'h0, if_pred_taken}, 32'h0);
        chk_perf("shad2");

        // JAL with branch also asserted at 0x40 (counter 2): no BHT touch.
        if_pc = 32'h40;
        do_ex("jal", 32'h40, 1, 1, 3'b000, 0, 0, 0, 32'h80, 1);
        exp_miss = sat_inc(exp_miss);
        chk("jal_flush", {31'h0, flush}, 32'h1);
        chk("jal_redirect", redirect_pc, 32'h80);
        chk("jal_pred", {31'h0, if_pred_taken}, 32'h1);
        chk_perf("jal");
        step();

        // funct3 010 at 0x40: never taken, counter 2 -> 1, branch count saturates.
        set_ex(32'h40, 1, 0, 3'b010, 1, 1, 0, 32'h900);
        #1;
        chk("f010_branch_res", {31'h0, branch_res}, 32'h0);
        chk("f010_no_bypass", {31'h0, if_pred_taken}, 32'h1);
        step();
        clr_ex();
        exp_br = sat_inc(exp_br);
        chk("f010_flush", {31'h0, flush}, 32'h0);
        chk("f010_pred", {31'h0, if_pred_taken}, 32'h0);
        chk_perf("f010");

        // Reset asserted during a flush cycle.
        do_ex("rst_mid", 32'h40, 1, 0, 3'b000, 1, 0, 0, 32'h400, 1);
        chk("rst_mid_flush", {31'h0, flush}, 32'h1);
        set_ex(32'h40, 1, 0, 3'b000, 1, 0, 0, 32'h400);
        #2;
        rst_n = 1'b0;
        #1;
        exp_br = 0; exp_miss = 0;
        chk("rst_async_flush", {31'h0, flush}, 32'h0);
        chk("rst_async_redirect", redirect_pc, 32'h0);
        chk_perf("rst_async");
        @(negedge clk);
        clr_ex();
        rst_n = 1'b1;
        #1;
        chk("rst_pred40", {31'h0, if_pred_taken}, 32'h0);
        if_pc = 32'h100;
        #1;
        chk("rst_pred100", {31'h0, if_pred_taken}, 32'h0);
        step();
        chk("rst_cold_flush", {31'h0, flush}, 32'h0);
        chk_perf("rst_cold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
